// File: rtl/parking_pkg.sv
// Shared constants for the car-park entrance gate controller.
// State encodings, seven-segment glyphs and the display decoder.
package parking_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRONG = 3'd2;
  localparam logic [2:0] S_RIGHT = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_N   = 7'b0101011;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_P   = 7'b0001100;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_U   = 7'b1000001;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_O   = 7'b0100011;

  // {hex_1, hex_2} for a state; full only matters in IDLE
  function automatic logic [13:0] glyphs(
    input logic [2:0] st,
    input logic       is_full
  );
    logic [13:0] g;
    g = {SEG_OFF, SEG_OFF};
    case (st)
      S_IDLE:  g = is_full ? {SEG_F, SEG_U} : {SEG_OFF, SEG_OFF};
      S_WAIT:  g = {SEG_E, SEG_N};
      S_WRONG: g = {SEG_E, SEG_E};
      S_RIGHT: g = {SEG_6, SEG_0};
      S_STOP:  g = {SEG_5, SEG_P};
      S_LOCK:  g = {SEG_L, SEG_O};
      default: g = {SEG_OFF, SEG_OFF};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_blink.sv
// LED blink divider: phase is on right after a restart and
// toggles every DIV cycles; exposes the next phase value.
module blink_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic phase_next_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_next_o = phase_d;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park entrance gate: password FSM with timeout, lockout,
// occupancy count and tailgate stop; outputs decoded from next state.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int                CAPACITY    = 8,
  parameter int                PASS_W      = 4,
  parameter logic [PASS_W-1:0] PASSWORD    = 4'b0110,
  parameter int                WAIT_CYCLES = 16,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCK_CYCLES = 32,
  parameter int                BLINK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sensor_entrance,
  input  logic                          sensor_exit,
  input  logic                          car_leave,
  input  logic                          pass_valid,
  input  logic [PASS_W-1:0]             password,
  output logic                          green_led,
  output logic                          red_led,
  output logic                          alarm,
  output logic                          full,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic [2:0]                    state_code,
  output logic [6:0]                    hex_1,
  output logic [6:0]                    hex_2
);

  localparam int OW = $clog2(CAPACITY + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [OW-1:0] CAP_V  = OW'(CAPACITY);
  localparam logic [WW-1:0] WAIT_L = WW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] TRY_V  = TW'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_L = LW'(LOCK_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic [LW-1:0] lock_q, lock_d;
  logic          green_q, red_q, alarm_q;
  logic [6:0]    hex1_q, hex2_q;
  logic          match, miss, is_full, inc, dec;
  logic          blink_d, restart;
  logic [13:0]   glyph_d;

  assign match     = pass_valid && (password == PASSWORD);
  assign miss      = pass_valid && (password != PASSWORD);
  assign is_full   = (occ_q == CAP_V);
  assign tries_inc = tries_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    case (state_q)
      S_IDLE: if (sensor_entrance && !is_full) state_d = S_WAIT;
      S_WAIT, S_WRONG: begin
        if (match) begin
          state_d = S_RIGHT;
        end else if (miss) begin
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_V) ? S_LOCK : S_WRONG;
        end else if (state_q == S_WAIT && wait_q == WAIT_L) begin
          state_d = S_IDLE;
        end
      end
      S_RIGHT: begin
        if (sensor_exit && sensor_entrance) state_d = S_STOP;
        else if (sensor_exit)               state_d = S_IDLE;
      end
      S_STOP: if (match) state_d = S_RIGHT;
      S_LOCK: if (lock_q == LOCK_L) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q && (state_d == S_IDLE || state_d == S_RIGHT))
      tries_d = '0;
  end

  // Dwell counters run only while staying in their state
  always_comb begin
    wait_d = '0;
    lock_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) wait_d = wait_q + 1'b1;
    if (state_q == S_LOCK && state_d == S_LOCK) lock_d = lock_q + 1'b1;
  end

  assign inc = (state_q == S_RIGHT) && (state_d == S_IDLE);
  assign dec = car_leave && (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (inc && !dec && occ_q != CAP_V) occ_d = occ_q + 1'b1;
    else if (dec && !inc)              occ_d = occ_q - 1'b1;
  end

  assign restart = (state_d != state_q);

  blink_gen #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk          (clk),
    .reset        (reset),
    .restart_i    (restart),
    .phase_next_o (blink_d)
  );

  assign glyph_d = glyphs(state_d, occ_d == CAP_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      wait_q  <= '0;
      tries_q <= '0;
      lock_q  <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      alarm_q <= 1'b0;
      hex1_q  <= SEG_OFF;
      hex2_q  <= SEG_OFF;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      wait_q  <= wait_d;
      tries_q <= tries_d;
      lock_q  <= lock_d;
      green_q <= (state_d == S_RIGHT) && blink_d;
      red_q   <= (state_d == S_WAIT) ||
                 (blink_d && (state_d == S_WRONG ||
                              state_d == S_STOP  ||
                              state_d == S_LOCK));
      alarm_q <= (state_d == S_LOCK);
      hex1_q  <= glyph_d[13:7];
      hex2_q  <= glyph_d[6:0];
    end
  end

  assign green_led  = green_q;
  assign red_led    = red_q;
  assign alarm      = alarm_q;
  assign full       = is_full;
  assign occupancy  = occ_q;
  assign state_code = state_q;
  assign hex_1      = hex1_q;
  assign hex_2      = hex2_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge; checks sample there too.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_entrance, sensor_exit, car_leave, pass_valid;
  logic [3:0] password;
  logic       green_led, red_led, alarm, full;
  logic [3:0] occupancy;
  logic [2:0] state_code;
  logic [6:0] hex_1, hex_2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .car_leave       (car_leave),
    .pass_valid      (pass_valid),
    .password        (password),
    .green_led       (green_led),
    .red_led         (red_led),
    .alarm           (alarm),
    .full            (full),
    .occupancy       (occupancy),
    .state_code      (state_code),
    .hex_1           (hex_1),
    .hex_2           (hex_2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hex_chk(input string tag, input logic [6:0] e1,
                         input logic [6:0] e2);
    check({tag, "_hex1"}, 32'(hex_1), 32'(e1));
    check({tag, "_hex2"}, 32'(hex_2), 32'(e2));
  endtask

  task automatic enter_right();
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    pass_valid = 1'b1; password = 4'b0110; step();
    pass_valid = 1'b0;
  endtask

  task automatic exit_car();
    sensor_exit = 1'b1; step();
    sensor_exit = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sensor_entrance = 1'b0; sensor_exit = 1'b0;
    car_leave = 1'b0; pass_valid = 1'b0; password = 4'h0;
    step(); step();
    reset = 1'b0;
    check("rst_state", 32'(state_code), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_full", 32'(full), 0);
    check("rst_leds", 32'({green_led, red_led, alarm}), 0);
    hex_chk("rst", 7'h7F, 7'h7F);

    // entry and correct password
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    check("wait_state", 32'(state_code), 1);
    check("wait_red", 32'(red_led), 1);
    hex_chk("wait", 7'h06, 7'h2B);
    pass_valid = 1'b1; password = 4'b0110; step();
    pass_valid = 1'b0;
    check("right_state", 32'(state_code), 3);
    check("right_green0", 32'(green_led), 1);
    hex_chk("right", 7'h02, 7'h40);
    repeat (3) step();
    check("green_on_c4", 32'(green_led), 1);
    step();
    check("green_off_c5", 32'(green_led), 0);
    repeat (3) step();
    check("green_off_c8", 32'(green_led), 0);
    step();
    check("green_on_c9", 32'(green_led), 1);
    exit_car();
    check("exit_state", 32'(state_code), 0);
    check("exit_occ", 32'(occupancy), 1);
    check("exit_green", 32'(green_led), 0);

    // three misses -> lockout
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    pass_valid = 1'b1; password = 4'b0000; step();
    check("miss1_state", 32'(state_code), 2);
    hex_chk("wrong", 7'h06, 7'h06);
    step();
    check("miss2_state", 32'(state_code), 2);
    step();
    check("miss3_state", 32'(state_code), 5);
    check("lock_alarm", 32'(alarm), 1);
    check("lock_red", 32'(red_led), 1);
    hex_chk("lock", 7'h47, 7'h23);
    password = 4'b0110; step();
    pass_valid = 1'b0;
    check("lock_ignores", 32'(state_code), 5);
    repeat (30) step();
    check("lock_c31", 32'(state_code), 5);
    check("lock_red_c31", 32'(red_led), 0);
    step();
    check("lock_exit", 32'(state_code), 0);
    check("lock_alarm_off", 32'(alarm), 0);

    // tries cleared: two misses stay in WRONG_PASS
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    pass_valid = 1'b1; password = 4'b1001; step(); step();
    check("tries_clr", 32'(state_code), 2);
    password = 4'b0110; step();
    pass_valid = 1'b0;
    check("wrong_match", 32'(state_code), 3);
    exit_car();
    check("occ2", 32'(occupancy), 2);

    // timeout, then a strobe on the last cycle
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    repeat (15) step();
    check("to_c15", 32'(state_code), 1);
    step();
    check("to_c16", 32'(state_code), 0);
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    repeat (15) step();
    pass_valid = 1'b1; password = 4'b0110; step();
    pass_valid = 1'b0;
    check("to_last_match", 32'(state_code), 3);

    // tailgate
    sensor_entrance = 1'b1; sensor_exit = 1'b1; step();
    sensor_entrance = 1'b0; sensor_exit = 1'b0;
    check("stop_state", 32'(state_code), 4);
    check("stop_red", 32'(red_led), 1);
    hex_chk("stop", 7'h12, 7'h0C);
    check("stop_occ", 32'(occupancy), 2);
    pass_valid = 1'b1; password = 4'b1111; step();
    check("stop_miss", 32'(state_code), 4);
    password = 4'b0110; step();
    pass_valid = 1'b0;
    check("stop_match", 32'(state_code), 3);
    exit_car();
    check("occ3", 32'(occupancy), 3);

    // fill to capacity
    repeat (5) begin
      enter_right();
      exit_car();
    end
    check("fill_occ", 32'(occupancy), 8);
    check("fill_full", 32'(full), 1);
    hex_chk("full", 7'h0E, 7'h41);
    sensor_entrance = 1'b1; step();
    check("full_refuse", 32'(state_code), 0);
    car_leave = 1'b1; step();
    car_leave = 1'b0;
    check("leave_occ", 32'(occupancy), 7);
    check("leave_full", 32'(full), 0);
    hex_chk("leave", 7'h7F, 7'h7F);
    step();
    sensor_entrance = 1'b0;
    check("reenter", 32'(state_code), 1);

    // exit and leave in the same cycle
    pass_valid = 1'b1; password = 4'b0110; step();
    pass_valid = 1'b0;
    sensor_exit = 1'b1; car_leave = 1'b1; step();
    sensor_exit = 1'b0; car_leave = 1'b0;
    check("both_state", 32'(state_code), 0);
    check("both_occ", 32'(occupancy), 7);

    // drain and underflow
    car_leave = 1'b1;
    repeat (7) step();
    check("drain_occ", 32'(occupancy), 0);
    step();
    car_leave = 1'b0;
    check("underflow", 32'(occupancy), 0);

    // reset mid-operation
    sensor_entrance = 1'b1; step();
    sensor_entrance = 1'b0;
    check("pre_rst", 32'(state_code), 1);
    reset = 1'b1; step();
    reset = 1'b0;
    check("mid_rst_state", 32'(state_code), 0);
    check("mid_rst_red", 32'(red_led), 0);
    hex_chk("mid_rst", 7'h7F, 7'h7F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Parametrised entrance-gate controller for the multi-space car park. It replaces the fixed single-password gate FSM and adds:
- a configurable password width and value, entered with a strobe;
- a password-entry timeout;
- lockout after repeated wrong attempts;
- an occupancy counter with a full flag that refuses entry;
- a tailgate stop.

It sits between the lane sensors and keypad on one side and the gate LEDs and two seven-segment digits on the other.

## Interface
- CAPACITY, 8: number of parking spaces (≥1).
- PASS_W, 4: password width in bits.
- PASSWORD, 4'b0110: accepted password, PASS_W bits.
- WAIT_CYCLES, 16: cycles allowed in WAIT_PASSWORD without a `pass_valid` before timeout (≥1).
- MAX_TRIES, 3: wrong entries that trigger lockout (≥1).
- LOCK_CYCLES, 32: lockout duration in cycles (≥1).
- BLINK_DIV, 4: cycles per LED blink half-period (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sensor_entrance  in  1  car present at the entry gate.
- sensor_exit  in  1  car has passed the entry gate.
- car_leave  in  1  one-cycle pulse: a car left via the exit lane.
- pass_valid  in  1  one-cycle strobe: `password` is valid.
- password  in  PASS_W  keypad value.
- green_led  out  1  gate open indicator.
- red_led  out  1  stop/error indicator.
- alarm  out  1  high while in LOCKOUT.
- full  out  1  occupancy == CAPACITY.
- occupancy  out  $clog2(CAPACITY+1)  cars inside.
- state_code  out  3  current state encoding.
- hex_1, hex_2  out  7  active-low segment patterns (gfedcba).

## Operation
- Moore FSM. State encodings: IDLE=0, WAIT_PASSWORD=1, WRONG_PASS=2, RIGHT_PASS=3, STOP=4, LOCKOUT=5.
- A "match" means `pass_valid` && `password == PASSWORD`. A "miss" means `pass_valid` && `password != PASSWORD`.
- IDLE:
  - `sensor_entrance` && !`full` → WAIT_PASSWORD.
  - Otherwise stay in IDLE.
- WAIT_PASSWORD:
  - match → RIGHT_PASS.
  - miss → increment tries. If the new tries == MAX_TRIES → LOCKOUT, else → WRONG_PASS.
  - No strobe for WAIT_CYCLES cycles → IDLE.
- WRONG_PASS: match → RIGHT_PASS. A miss is handled as in WAIT_PASSWORD. There is no timeout.
- RIGHT_PASS:
  - `sensor_entrance` && `sensor_exit` → STOP (tailgate).
  - `sensor_exit` alone → IDLE and occupancy +1 (saturates at CAPACITY).
- STOP: match → RIGHT_PASS. Misses are ignored and do not count as tries.
- LOCKOUT: after LOCK_CYCLES cycles → IDLE. All inputs are ignored.
- Tries counter: cleared on entry to IDLE and on entry to RIGHT_PASS.
- Occupancy:
  - `car_leave` decrements the count when it is >0; at 0 the pulse is ignored.
  - Increment and decrement in the same cycle leave the count unchanged.
  - `full` is combinational from `occupancy`.
- LEDs:
  - green_led = blink in RIGHT_PASS, else 0.
  - red_led = 1 in WAIT_PASSWORD; blink in WRONG_PASS, STOP and LOCKOUT; else 0.
  - alarm = 1 only in LOCKOUT.
  - Blink starts on (1) at state entry and toggles every BLINK_DIV cycles.
- Displays (hex_1/hex_2):
  - IDLE not full: off/off (1111111).
  - IDLE full: "F" 0001110 / "U" 1000001.
  - WAIT_PASSWORD: "E" 0000110 / "n" 0101011.
  - WRONG_PASS: "E" / "E".
  - RIGHT_PASS: "6" 0000010 / "0" 1000000.
  - STOP: "5" 0010010 / "P" 0001100.
  - LOCKOUT: "L" 1000111 / "o" 0100011.

## Timing
- All state, counters and outputs are registered on the rising edge of `clk`.
- Outputs are decoded from next-state, so they are valid in the same cycle as `state_code`. Latency from input to output is one edge.
- Reset values:
  - state IDLE; occupancy 0; tries 0.
  - All LEDs and `alarm` 0; hex_1/hex_2 1111111; `full` = (CAPACITY==0 ? 1 : 0), which is 0 for legal parameters.
- Reset asserted mid-operation overrides everything, including an occupancy update in the same cycle.
- WAIT_PASSWORD timeout counter starts at 0 on entry. The transition occurs on the edge where WAIT_CYCLES cycles have elapsed without a strobe. A strobe arriving in the last cycle wins over the timeout.
- LOCKOUT counter starts at 0 on entry. The FSM is back in IDLE exactly LOCK_CYCLES cycles after entering LOCKOUT.
- Inputs are assumed synchronous to `clk`. No synchroniser is included in this block.

## Structure
- Package `parking_pkg` holds:
  - the state enum/localparams;
  - the seven-segment glyph constants (off, E, n, 6, 0, 5, P, F, U, L, o).
- One sub-module, `blink_gen`: a divider with a restart input, producing the blink phase.

## Test plan
- Reset, then `sensor_entrance`=1, then `pass_valid` with 4'b0110 → WAIT_PASSWORD → RIGHT_PASS, green blinking with period 8, hex "60". Then `sensor_exit` → IDLE, occupancy=1.
- Three misses (4'b0000) → WRONG_PASS after the 1st and 2nd, LOCKOUT after the 3rd. `alarm`=1, hex "Lo" for 32 cycles, then IDLE with tries=0.
- Enter WAIT_PASSWORD and give no strobe → IDLE after 16 cycles. A match on cycle 16 → RIGHT_PASS.
- In RIGHT_PASS, `sensor_entrance`=`sensor_exit`=1 → STOP, hex "5P". A miss stays in STOP; a match → RIGHT_PASS.
- Fill to 8 cars → `full`=1, hex "FU", `sensor_entrance` ignored. A `car_leave` pulse gives 7 and entry is allowed again.
- `car_leave` at occupancy 0 → stays 0. `car_leave` in the same cycle as a RIGHT_PASS exit → occupancy unchanged.
